serial_frame_rx: RTL and testbench

- Serial-in/parallel-out frame receiver. It is the receiving end for the parallel-load/serial-shift transmitter block.
- It detects a start bit on a one-bit serial line and shifts in WIDTH data bits, one per clock. It then checks a stop bit and presents the assembled word on a valid/ack handshake.
- Sits between the serial link and the consuming datapath. It reports framing errors and overruns.

---
 rtl/serial_frame_rx.sv | 86 ++++++++
 tb/tb_serial_frame_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/stop framed serial-in parallel-out receiver with valid/ack output
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    // Counter has to hold WIDTH because it increments once more on the last data bit.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;

    // busy comes straight from the registered state so it has no extra delay.
    assign busy = (state != IDLE);

    // Frame state machine, shift register, output word and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // The consumer's ack frees the holding word. A good stop on the same
            // edge can still reload it below.
            if (valid && ack) begin
                valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!din) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (LSB_FIRST) begin
                        sreg <= {din, sreg[WIDTH-1:1]};
                    end else begin
                        sreg <= {sreg[WIDTH-2:0], din};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    state <= IDLE;
                    if (din) begin
                        if (!valid || ack) begin
                            dout  <= sreg;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard bench for serial_frame_rx (LSB-first and MSB-first instances)
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       ack;
    logic       ack1;
    logic [3:0] dout;
    logic       valid, busy, frame_err, overrun;
    logic [3:0] dout1;
    logic       valid1, busy1, frame_err1, overrun1;

    int         n_total = 0;
    int         n_pass  = 0;
    int         busy_cnt;
    int         fe_cnt;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .ack(ack),
        .dout(dout), .valid(valid), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    serial_frame_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .ack(ack1),
        .dout(dout1), .valid(valid1), .busy(busy1),
        .frame_err(frame_err1), .overrun(overrun1)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: every accepted word (valid && ack) must match the next expected word.
    always @(negedge clk) begin
        if (!rst && valid && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {28'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                check("scoreboard_word", {28'd0, dout}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one bit for one clock, then observe busy and frame_err just after the edge.
    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
        busy_cnt += int'(busy);
        fe_cnt   += int'(frame_err);
    endtask

    // Frame with word[0] sent first; optional ack on the start-bit and stop-bit cycles.
    task automatic send_frame(input logic [3:0] word, input logic stop,
                              input logic ack_first, input logic ack_stop);
        ack = ack_first;
        send_bit(1'b0);
        ack = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(word[i]);
        ack = ack_stop;
        send_bit(stop);
        ack = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        send_bit(1'b1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b1; ack = 1'b0; ack1 = 1'b0;
        busy_cnt = 0; fe_cnt = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_dout", {28'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        send_bit(1'b1);

        // Good frame: din 0,0,1,0,1,1
        exp_q.push_back(4'b1010);
        busy_cnt = 0; fe_cnt = 0;
        send_frame(4'b1010, 1'b1, 1'b0, 1'b0);
        check("good_valid", {31'd0, valid}, 32'd1);
        check("good_dout", {28'd0, dout}, 32'hA);
        check("msb_first_dout", {28'd0, dout1}, 32'h5);
        send_bit(1'b1);
        check("good_busy_cycles", busy_cnt, 5);
        check("good_frame_err", fe_cnt, 0);

        // Handshake: ack low three cycles, then one ack, then a stray ack.
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            check("hold_dout", {28'd0, dout}, 32'hA);
            check("hold_valid", {31'd0, valid}, 32'd1);
        end
        pulse_ack();
        check("ack_clears_valid", {31'd0, valid}, 32'd0);
        pulse_ack();
        check("stray_ack_valid", {31'd0, valid}, 32'd0);
        check("stray_ack_dout", {28'd0, dout}, 32'hA);

        // Framing error: din 0,1,1,1,1,0 then idle.
        busy_cnt = 0; fe_cnt = 0;
        send_frame(4'b1111, 1'b0, 1'b0, 1'b0);
        check("ferr_pulse_now", {31'd0, frame_err}, 32'd1);
        send_bit(1'b1);
        check("ferr_one_cycle", fe_cnt, 1);
        check("ferr_dout", {28'd0, dout}, 32'hA);
        check("ferr_valid", {31'd0, valid}, 32'd0);
        check("ferr_idle", {31'd0, busy}, 32'd0);
        check("ferr_overrun", {31'd0, overrun}, 32'd0);

        // Overrun: A unacked, then B dropped.
        exp_q.push_back(4'b0101);
        send_frame(4'b0101, 1'b1, 1'b0, 1'b0);
        send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
        check("ovr_dout", {28'd0, dout}, 32'h5);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_valid", {31'd0, valid}, 32'd1);

        // Ack on the stop edge of the next frame: A accepted, new word loaded.
        exp_q.push_back(4'b0011);
        send_frame(4'b0011, 1'b1, 1'b0, 1'b1);
        check("simul_dout", {28'd0, dout}, 32'h3);
        check("simul_valid", {31'd0, valid}, 32'd1);
        check("simul_overrun", {31'd0, overrun}, 32'd1);
        pulse_ack();
        check("simul_acked", {31'd0, valid}, 32'd0);

        // Back-to-back frames, first word acked during the second start bit.
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b1001);
        busy_cnt = 0;
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
        send_frame(4'b1001, 1'b1, 1'b1, 1'b0);
        check("b2b_busy_cycles", busy_cnt, 10);
        check("b2b_dout", {28'd0, dout}, 32'h9);
        check("b2b_valid", {31'd0, valid}, 32'd1);
        pulse_ack();
        check("b2b_acked", {31'd0, valid}, 32'd0);

        // Reset after the second data bit.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b0);
        rst = 1'b0;
        check("mid_rst_dout", {28'd0, dout}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        check("post_rst_no_valid", {31'd0, valid}, 32'd0);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
